// File: rtl/atomik_event_framer.sv
// Event framer: captures one event per ev_valid/ev_ready handshake and serializes it as a
// 6-byte frame (sync, flags, addr hi, addr lo, delta value, XOR checksum) on a byte stream.
module atomik_event_framer #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ev_valid,
  output logic              ev_ready,
  input  logic              ev_delta,
  input  logic              ev_first_touch,
  input  logic              ev_drop_invalid,
  input  logic [ADDR_W-1:0] ev_addr,
  input  logic [3:0]        ev_delta_val,
  input  logic              ev_is_zero,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic [31:0]       cnt_frames,
  output logic [31:0]       cnt_tx_stalls
);

  localparam logic [2:0] LastIdx = 3'd5;

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } state_e;

  state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;

  // Captured event fields; frame bytes derive only from these and idx_q
  logic              delta_q;
  logic              first_touch_q;
  logic              drop_invalid_q;
  logic              is_zero_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        delta_val_q;

  logic [31:0] cnt_frames_q, cnt_frames_d;
  logic [31:0] cnt_tx_stalls_q, cnt_tx_stalls_d;

  logic accept;
  logic tx_fire;
  logic tx_stall;
  logic last_byte;

  logic [15:0] addr16;
  logic [7:0]  flags_byte;
  logic [7:0]  dval_byte;
  logic [7:0]  cksum_byte;
  logic [7:0]  frame_byte;

  // Handshake decode; both sides are pure functions of state so reset clears them at once
  always_comb begin
    ev_ready  = (state_q == StIdle);
    tx_valid  = (state_q == StSend);
    busy      = (state_q == StSend);
    accept    = ev_valid && ev_ready;
    tx_fire   = tx_valid && tx_ready;
    tx_stall  = tx_valid && !tx_ready;
    last_byte = (idx_q == LastIdx);
  end

  // Next-state: IDLE accepts one event, SEND walks idx 0..5 on each accepted byte
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StSend;
          idx_d   = 3'd0;
        end
      end
      StSend: begin
        if (tx_fire) begin
          if (last_byte) begin
            state_d = StIdle;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = 3'd0;
      end
    endcase
  end

  // State and byte index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Event capture; held for the whole frame so upstream changes cannot leak in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delta_q        <= 1'b0;
      first_touch_q  <= 1'b0;
      drop_invalid_q <= 1'b0;
      is_zero_q      <= 1'b0;
      addr_q         <= '0;
      delta_val_q    <= 4'h0;
    end else if (accept) begin
      delta_q        <= ev_delta;
      first_touch_q  <= ev_first_touch;
      drop_invalid_q <= ev_drop_invalid;
      is_zero_q      <= ev_is_zero;
      addr_q         <= ev_addr;
      delta_val_q    <= ev_delta_val;
    end
  end

  // Telemetry next values; both counters wrap naturally at 2^32
  always_comb begin
    cnt_frames_d    = cnt_frames_q;
    cnt_tx_stalls_d = cnt_tx_stalls_q;
    if (tx_fire && last_byte) begin
      cnt_frames_d = cnt_frames_q + 32'd1;
    end
    if (tx_stall) begin
      cnt_tx_stalls_d = cnt_tx_stalls_q + 32'd1;
    end
  end

  // Telemetry registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_frames_q    <= 32'd0;
      cnt_tx_stalls_q <= 32'd0;
    end else begin
      cnt_frames_q    <= cnt_frames_d;
      cnt_tx_stalls_q <= cnt_tx_stalls_d;
    end
  end

  assign cnt_frames    = cnt_frames_q;
  assign cnt_tx_stalls = cnt_tx_stalls_q;

  // Frame byte assembly; address zero-extended to 16 bits, checksum excludes the sync byte
  always_comb begin
    addr16               = 16'h0000;
    addr16[ADDR_W-1:0]   = addr_q;
    flags_byte           = {4'h0, is_zero_q, drop_invalid_q, first_touch_q, delta_q};
    dval_byte            = {4'h0, delta_val_q};
    cksum_byte           = flags_byte ^ addr16[15:8] ^ addr16[7:0] ^ dval_byte;
    frame_byte           = 8'h00;
    unique case (idx_q)
      3'd0:    frame_byte = SYNC_BYTE;
      3'd1:    frame_byte = flags_byte;
      3'd2:    frame_byte = addr16[15:8];
      3'd3:    frame_byte = addr16[7:0];
      3'd4:    frame_byte = dval_byte;
      3'd5:    frame_byte = cksum_byte;
      default: frame_byte = 8'h00;
    endcase
    // Outside a frame the bus idles at zero rather than showing a stale sync byte
    tx_data = tx_valid ? frame_byte : 8'h00;
  end

endmodule

// File: tb/tb_atomik_event_framer.sv
// Directed bench for atomik_event_framer: frames, flag encoding, backpressure,
// back-to-back events, mid-frame reset and ignored input while busy.
module tb_atomik_event_framer;

  logic        clk;
  logic        rst_n;
  logic        ev_valid;
  logic        ev_ready;
  logic        ev_delta;
  logic        ev_first_touch;
  logic        ev_drop_invalid;
  logic [9:0]  ev_addr;
  logic [3:0]  ev_delta_val;
  logic        ev_is_zero;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        busy;
  logic [31:0] cnt_frames;
  logic [31:0] cnt_tx_stalls;

  int n_cmp;
  int n_fail;

  atomik_event_framer #(
    .ADDR_W   (10),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ev_valid       (ev_valid),
    .ev_ready       (ev_ready),
    .ev_delta       (ev_delta),
    .ev_first_touch (ev_first_touch),
    .ev_drop_invalid(ev_drop_invalid),
    .ev_addr        (ev_addr),
    .ev_delta_val   (ev_delta_val),
    .ev_is_zero     (ev_is_zero),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .tx_data        (tx_data),
    .busy           (busy),
    .cnt_frames     (cnt_frames),
    .cnt_tx_stalls  (cnt_tx_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected frames, computed by hand
  logic [7:0] f_basic [6] = '{8'hA5, 8'h01, 8'h02, 8'h7A, 8'h09, 8'h70};
  logic [7:0] f_flags [6] = '{8'hA5, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h0A};
  logic [7:0] f_a     [6] = '{8'hA5, 8'h06, 8'h03, 8'hC5, 8'h06, 8'hC6};
  logic [7:0] f_b     [6] = '{8'hA5, 8'h09, 8'h01, 8'h00, 8'h0F, 8'h07};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_event(input logic d, input logic ft, input logic dr, input logic [9:0] a,
                           input logic [3:0] dv, input logic z);
    ev_delta        = d;
    ev_first_touch  = ft;
    ev_drop_invalid = dr;
    ev_addr         = a;
    ev_delta_val    = dv;
    ev_is_zero      = z;
  endtask

  // Present ev_valid for one edge; on return the DUT should show byte 0
  task automatic accept_event(input string name);
    n_cmp++;
    if (ev_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ev_ready before accept: got %b want 1", name, ev_ready);
    end
    ev_valid = 1'b1;
    step();
    ev_valid = 1'b0;
  endtask

  // Receive a frame; optionally hold tx_ready low for stall_n cycles at byte stall_at
  task automatic recv_frame(input string name, input logic [7:0] exp [6], input int stall_at,
                            input int stall_n);
    for (int i = 0; i < 6; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          tx_ready = 1'b0;
          n_cmp++;
          if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin
            n_fail++;
            $display("FAIL %s stall byte%0d cyc%0d: got v=%b d=%h want v=1 d=%h", name, i, s,
                     tx_valid, tx_data, exp[i]);
          end
          step();
        end
      end
      tx_ready = 1'b1;
      n_cmp++;
      if (tx_valid !== 1'b1 || tx_data !== exp[i] || ev_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s byte%0d: got v=%b d=%h rdy=%b busy=%b want v=1 d=%h rdy=0 busy=1",
                 name, i, tx_valid, tx_data, ev_ready, busy, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    ev_valid = 1'b0;
    tx_ready = 1'b1;
    set_event(1'b0, 1'b0, 1'b0, 10'h000, 4'h0, 1'b0);
    step();
    step();
    n_cmp++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%h busy=%b want 0 00 0", tx_valid, tx_data, busy);
    end
    n_cmp++;
    if (cnt_frames !== 32'd0 || cnt_tx_stalls !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0", cnt_frames, cnt_tx_stalls);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (ev_ready !== 1'b1 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b v=%b want 1 0", ev_ready, tx_valid);
    end
  endtask

  task automatic test_basic();
    set_event(1'b1, 1'b0, 1'b0, 10'h27A, 4'h9, 1'b0);
    accept_event("basic");
    recv_frame("basic", f_basic, -1, 0);
    n_cmp++;
    if (cnt_frames !== 32'd1 || ev_ready !== 1'b1 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_end: got frames=%0d rdy=%b v=%b want 1 1 0", cnt_frames, ev_ready,
               tx_valid);
    end
  endtask

  task automatic test_flags();
    set_event(1'b0, 1'b1, 1'b0, 10'h000, 4'h0, 1'b1);
    accept_event("flags");
    recv_frame("flags", f_flags, -1, 0);
    n_cmp++;
    if (cnt_frames !== 32'd2) begin
      n_fail++;
      $display("FAIL flags_count: got %0d want 2", cnt_frames);
    end
  endtask

  task automatic test_backpressure();
    // tx_ready idle-high before this point never stalls, so the counter starts at 0
    set_event(1'b1, 1'b0, 1'b0, 10'h27A, 4'h9, 1'b0);
    accept_event("bp");
    recv_frame("bp", f_basic, 2, 5);
    n_cmp++;
    if (cnt_tx_stalls !== 32'd5 || cnt_frames !== 32'd3) begin
      n_fail++;
      $display("FAIL bp_counts: got stalls=%0d frames=%0d want 5 3", cnt_tx_stalls, cnt_frames);
    end
  endtask

  task automatic test_back_to_back();
    set_event(1'b0, 1'b1, 1'b1, 10'h3C5, 4'h6, 1'b0);
    ev_valid = 1'b1;
    step();
    // Event B held on the inputs through A's frame must not corrupt A
    set_event(1'b1, 1'b0, 1'b0, 10'h100, 4'hF, 1'b1);
    recv_frame("b2b_a", f_a, -1, 0);
    n_cmp++;
    if (ev_ready !== 1'b1 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: got rdy=%b v=%b want 1 0", ev_ready, tx_valid);
    end
    step();
    ev_valid = 1'b0;
    recv_frame("b2b_b", f_b, -1, 0);
    n_cmp++;
    if (cnt_frames !== 32'd5) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d want 5", cnt_frames);
    end
  endtask

  task automatic test_reset_mid_frame();
    set_event(1'b1, 1'b0, 1'b0, 10'h27A, 4'h9, 1'b0);
    accept_event("rst_mid");
    tx_ready = 1'b1;
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || cnt_frames !== 32'd0 ||
        cnt_tx_stalls !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid_during: got v=%b busy=%b frames=%0d stalls=%0d want 0 0 0 0",
               tx_valid, busy, cnt_frames, cnt_tx_stalls);
    end
    step();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (ev_ready !== 1'b1 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_release: got rdy=%b v=%b want 1 0", ev_ready, tx_valid);
    end
    set_event(1'b0, 1'b1, 1'b0, 10'h000, 4'h0, 1'b1);
    accept_event("rst_mid_next");
    recv_frame("rst_mid_next", f_flags, -1, 0);
    n_cmp++;
    if (cnt_frames !== 32'd1) begin
      n_fail++;
      $display("FAIL rst_mid_count: got %0d want 1", cnt_frames);
    end
  endtask

  task automatic test_ignored_input();
    set_event(1'b1, 1'b0, 1'b0, 10'h27A, 4'h9, 1'b0);
    accept_event("ign");
    step();
    step();
    // One-cycle pulse of a different event while busy
    set_event(1'b0, 1'b1, 1'b1, 10'h3FF, 4'hF, 1'b1);
    ev_valid = 1'b1;
    n_cmp++;
    if (tx_data !== 8'h02 || ev_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_mid: got d=%h rdy=%b want 02 0", tx_data, ev_ready);
    end
    step();
    ev_valid = 1'b0;
    n_cmp++;
    if (tx_data !== 8'h7A) begin
      n_fail++;
      $display("FAIL ign_byte3: got %h want 7a", tx_data);
    end
    step();
    n_cmp++;
    if (tx_data !== 8'h09) begin
      n_fail++;
      $display("FAIL ign_byte4: got %h want 09", tx_data);
    end
    step();
    n_cmp++;
    if (tx_data !== 8'h70) begin
      n_fail++;
      $display("FAIL ign_byte5: got %h want 70", tx_data);
    end
    step();
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (tx_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL ign_idle%0d: got v=%b busy=%b want 0 0", i, tx_valid, busy);
      end
      step();
    end
    n_cmp++;
    if (cnt_frames !== 32'd2) begin
      n_fail++;
      $display("FAIL ign_count: got %0d want 2", cnt_frames);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_flags();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    test_ignored_input();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
